// File: rtl/lsu_pkg.sv
// Shared size encodings, FSM state type and lane helpers for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] LDST_B  = 3'd0;
  localparam logic [2:0] LDST_H  = 3'd1;
  localparam logic [2:0] LDST_W  = 3'd2;
  localparam logic [2:0] LDST_BU = 3'd4;
  localparam logic [2:0] LDST_HU = 3'd5;

  typedef enum logic [0:0] {
    LSU_IDLE = 1'b0,
    LSU_WAIT = 1'b1
  } lsu_state_e;

  function automatic logic is_byte(input logic [2:0] size);
    return (size == LDST_B) || (size == LDST_BU);
  endfunction

  function automatic logic is_half(input logic [2:0] size);
    return (size == LDST_H) || (size == LDST_HU);
  endfunction

  // Reserved encodings fall through to the word case.
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] lane);
    if (is_byte(size))      return 4'b0001 << lane;
    else if (is_half(size)) return lane[1] ? 4'b1100 : 4'b0011;
    else                    return 4'b1111;
  endfunction

  function automatic logic [31:0] store_data(input logic [2:0] size, input logic [31:0] wd);
    if (is_byte(size))      return {4{wd[7:0]}};
    else if (is_half(size)) return {2{wd[15:0]}};
    else                    return wd;
  endfunction

  function automatic logic misaligned(input logic [2:0] size, input logic [1:0] lane);
    if (is_byte(size))      return 1'b0;
    else if (is_half(size)) return lane[0];
    else                    return lane != 2'b00;
  endfunction

endpackage

// File: rtl/lsu_controller_if.sv
// Core-side and memory-side bundles of the load/store unit.
interface lsu_core_if;
  logic        core_req_i;
  logic        core_we_i;
  logic [2:0]  core_size_i;
  logic [31:0] core_addr_i;
  logic [31:0] core_wd_i;
  logic [31:0] core_rd_o;
  logic        core_stall_o;

  modport master (output core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
                  input  core_rd_o, core_stall_o);
  modport slave  (input  core_req_i, core_we_i, core_size_i, core_addr_i, core_wd_i,
                  output core_rd_o, core_stall_o);
endinterface

interface lsu_mem_if;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_wd_o;
  logic [31:0] mem_rd_i;
  logic        mem_ready_i;

  modport master (output mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
                  input  mem_rd_i, mem_ready_i);
  modport slave  (input  mem_req_o, mem_we_o, mem_be_o, mem_addr_o, mem_wd_o,
                  output mem_rd_i, mem_ready_i);
endinterface

// File: rtl/lsu_load_formatter.sv
// Selects the addressed byte/halfword of a memory word and sign- or zero-extends it.
module lsu_load_formatter
  import lsu_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [2:0]  size_i,
  input  logic [1:0]  lane_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (lane_i)
      2'd0:    byte_sel = rdata_i[7:0];
      2'd1:    byte_sel = rdata_i[15:8];
      2'd2:    byte_sel = rdata_i[23:16];
      default: byte_sel = rdata_i[31:24];
    endcase
    half_sel = lane_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    case (size_i)
      LDST_B:  data_o = {{24{byte_sel[7]}}, byte_sel};
      LDST_BU: data_o = {24'h0, byte_sel};
      LDST_H:  data_o = {{16{half_sel[15]}}, half_sel};
      LDST_HU: data_o = {16'h0, half_sel};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/lsu_controller.sv
// Two-state load/store unit: issues in IDLE, holds the access in WAIT until ready or timeout.
// Optional misalignment rejection is built when LSU_MISALIGN_CHECK_EN is defined.
module lsu_controller
  import lsu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic      clk_i,
  input  logic      rst_i,
  lsu_core_if.slave core,
  lsu_mem_if.master mem,
  output logic      bus_err_o,
  output logic      misalign_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 2);

  lsu_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      addr_q;
  logic [31:0]      wd_q;
  logic [3:0]       be_q;
  logic [2:0]       size_q;
  logic             we_q;

  logic        illegal;
  logic        issue;
  logic        in_wait;
  logic        timeout;
  logic        done;
  logic        active;
  logic [31:0] fmt_data;

`ifdef LSU_MISALIGN_CHECK_EN
  assign illegal    = misaligned(core.core_size_i, core.core_addr_i[1:0]);
  assign misalign_o = rst_i && (state_q == LSU_IDLE) && core.core_req_i && illegal;
`else
  assign illegal    = 1'b0;
  assign misalign_o = 1'b0;
`endif

  // rst_i gates the combinational paths so reset silences outputs without a clock edge.
  assign issue   = rst_i && (state_q == LSU_IDLE) && core.core_req_i && !illegal;
  assign in_wait = rst_i && (state_q == LSU_WAIT);
  assign done    = in_wait && mem.mem_ready_i;
  assign timeout = in_wait && !mem.mem_ready_i && (TIMEOUT_CYCLES != 0) &&
                   ((32'(cnt_q) + 32'd1) == TIMEOUT_CYCLES);
  assign active  = in_wait && !timeout;

  assign mem.mem_req_o  = issue || active;
  assign mem.mem_we_o   = issue ? core.core_we_i : (active ? we_q : 1'b0);
  assign mem.mem_be_o   = issue ? byte_en(core.core_size_i, core.core_addr_i[1:0])
                                : (active ? be_q : 4'b0000);
  assign mem.mem_addr_o = issue ? {core.core_addr_i[31:2], 2'b00}
                                : (active ? {addr_q[31:2], 2'b00} : 32'h0);
  assign mem.mem_wd_o   = issue ? store_data(core.core_size_i, core.core_wd_i)
                                : (active ? wd_q : 32'h0);

  assign core.core_stall_o = issue || (active && !mem.mem_ready_i);
  assign core.core_rd_o    = done ? fmt_data : 32'h0;
  assign bus_err_o         = timeout;

  lsu_load_formatter u_fmt (
    .rdata_i (mem.mem_rd_i),
    .size_i  (size_q),
    .lane_i  (addr_q[1:0]),
    .data_o  (fmt_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (issue) begin
      state_d = LSU_WAIT;
      cnt_d   = '0;
    end else if (in_wait) begin
      if (mem.mem_ready_i || timeout) state_d = LSU_IDLE;
      else                            cnt_d   = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= LSU_IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'h0;
      wd_q    <= 32'h0;
      be_q    <= 4'b0000;
      size_q  <= LDST_W;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (issue) begin
        addr_q <= core.core_addr_i;
        wd_q   <= store_data(core.core_size_i, core.core_wd_i);
        be_q   <= byte_en(core.core_size_i, core.core_addr_i[1:0]);
        size_q <= core.core_size_i;
        we_q   <= core.core_we_i;
      end
    end
  end

endmodule

// File: tb/tb_lsu_controller.sv
// Directed bench for lsu_controller (TIMEOUT_CYCLES=4); misalign expectations follow LSU_MISALIGN_CHECK_EN.
module tb_lsu_controller;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic bus_err;
  logic misalign;
  int   checks = 0;
  int   errors = 0;

  lsu_core_if core_bus ();
  lsu_mem_if  mem_bus ();

  lsu_controller #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .core       (core_bus),
    .mem        (mem_bus),
    .bus_err_o  (bus_err),
    .misalign_o (misalign)
  );

  always #5 clk = ~clk;

  // {mem_req, core_stall, mem_we, mem_be}
  wire [6:0] ctl = {mem_bus.mem_req_o, core_bus.core_stall_o, mem_bus.mem_we_o, mem_bus.mem_be_o};
  // {mem_req, core_stall, bus_err}
  wire [2:0] hs  = {mem_bus.mem_req_o, core_bus.core_stall_o, bus_err};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic req, input logic we, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic ready, input logic [31:0] rdata);
    core_bus.core_req_i  = req;
    core_bus.core_we_i   = we;
    core_bus.core_size_i = size;
    core_bus.core_addr_i = addr;
    core_bus.core_wd_i   = wd;
    mem_bus.mem_ready_i  = ready;
    mem_bus.mem_rd_i     = rdata;
    #1;
  endtask

  task automatic test_reset();
    drive(1, 1, 3'd0, 32'h0000_0001, 32'hFFFF_FFFF, 1, 32'h1234_5678);
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, 7'b0000000); end
    checks++; if (core_bus.core_rd_o !== 32'h0) begin errors++; $display("FAIL reset_rd got=%h exp=%h", core_bus.core_rd_o, 32'h0); end
    checks++; if ({bus_err, misalign} !== 2'b00) begin errors++; $display("FAIL reset_faults got=%b exp=%b", {bus_err, misalign}, 2'b00); end
    drive(0, 0, 3'd2, 32'h0, 32'h0, 0, 32'h0);
    step(); rst_n = 1'b1;
    drive(0, 0, 3'd2, 32'h0, 32'h0, 0, 32'h0);
    checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL idle_noreq_ctl got=%b exp=%b", ctl, 7'b0000000); end
    $display("reset released, idle ctl=%b", ctl);
  endtask

  task automatic test_load_byte();
    step(); drive(1, 0, 3'd0, 32'h0000_0103, 32'h0, 0, 32'h0);
    checks++; if (ctl !== 7'b1101000) begin errors++; $display("FAIL lb_issue_ctl got=%b exp=%b", ctl, 7'b1101000); end
    checks++; if (mem_bus.mem_addr_o !== 32'h0000_0100) begin errors++; $display("FAIL lb_issue_addr got=%h exp=%h", mem_bus.mem_addr_o, 32'h100); end
    step(); drive(0, 0, 3'd0, 32'h0, 32'h0, 1, 32'h80FF_0000);
    checks++; if (ctl !== 7'b1001000) begin errors++; $display("FAIL lb_ready_ctl got=%b exp=%b", ctl, 7'b1001000); end
    checks++; if (core_bus.core_rd_o !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_rd got=%h exp=%h", core_bus.core_rd_o, 32'hFFFF_FF80); end
    step(); drive(0, 0, 3'd0, 32'h0, 32'h0, 0, 32'h0);
    checks++; if (ctl !== 7'b0000000) begin errors++; $display("FAIL lb_after_ctl got=%b exp=%b", ctl, 7'b0000000); end
    $display("load B addr=00000103 rd=ffffff80");
  endtask

  task automatic test_store_formats();
    step(); drive(1, 1, 3'd1, 32'h0000_0012, 32'h0000_ABCD, 0, 32'h0);
    checks++; if (ctl !== 7'b1111100) begin errors++; $display("FAIL sh_issue_ctl got=%b exp=%b", ctl, 7'b1111100); end
    checks++; if (mem_bus.mem_wd_o !== 32'hABCD_ABCD) begin errors++; $display("FAIL sh_wd got=%h exp=%h", mem_bus.mem_wd_o, 32'hABCD_ABCD); end
    checks++; if (mem_bus.mem_addr_o !== 32'h0000_0010) begin errors++; $display("FAIL sh_addr got=%h exp=%h", mem_bus.mem_addr_o, 32'h10); end
    step(); drive(1, 0, 3'd2, 32'hFFFF_FFFF, 32'h1111_2222, 0, 32'h0);
    checks++; if ({ctl, mem_bus.mem_addr_o, mem_bus.mem_wd_o} !== {7'b1111100, 32'h10, 32'hABCD_ABCD}) begin errors++;
      $display("FAIL sh_hold got=%b/%h/%h exp=1111100/00000010/abcdabcd", ctl, mem_bus.mem_addr_o, mem_bus.mem_wd_o); end
    step(); drive(0, 0, 3'd2, 32'h0, 32'h0, 1, 32'h0);
    checks++; if (ctl !== 7'b1011100) begin errors++; $display("FAIL sh_ready_ctl got=%b exp=%b", ctl, 7'b1011100); end
    $display("store H addr=00000012 wd=abcdabcd be=1100");
    step(); drive(1, 1, 3'd0, 32'h0000_0201, 32'h1234_56A5, 0, 32'h0);
    checks++; if ({ctl, mem_bus.mem_addr_o, mem_bus.mem_wd_o} !== {7'b1110010, 32'h200, 32'hA5A5_A5A5}) begin errors++;
      $display("FAIL sb_issue got=%b/%h/%h exp=1110010/00000200/a5a5a5a5", ctl, mem_bus.mem_addr_o, mem_bus.mem_wd_o); end
    step(); drive(0, 0, 3'd0, 32'h0, 32'h0, 1, 32'h0);
    $display("store B addr=00000201 wd=a5a5a5a5 be=0010");
    step(); drive(1, 1, 3'd2, 32'h0000_0204, 32'hCAFE_F00D, 0, 32'h0);
    checks++; if ({ctl, mem_bus.mem_addr_o, mem_bus.mem_wd_o} !== {7'b1111111, 32'h204, 32'hCAFE_F00D}) begin errors++;
      $display("FAIL sw_issue got=%b/%h/%h exp=1111111/00000204/cafef00d", ctl, mem_bus.mem_addr_o, mem_bus.mem_wd_o); end
    step(); drive(0, 0, 3'd0, 32'h0, 32'h0, 1, 32'h0);
    $display("store W addr=00000204 wd=cafef00d be=1111");
  endtask

  task automatic test_load_formats();
    logic [2:0]  sz [8] = '{3'd1, 3'd5, 3'd1, 3'd4, 3'd0, 3'd2, 3'd3, 3'd6};
    logic [31:0] ad [8] = '{32'h2, 32'h2, 32'h0, 32'h1, 32'h2, 32'h0, 32'h8, 32'hC};
    logic [31:0] rd [8] = '{32'h8001_7FFF, 32'h8001_7FFF, 32'h8001_7FFF, 32'h0000_F200,
                            32'h0055_0000, 32'hDEAD_BEEF, 32'h1234_5678, 32'h8000_0001};
    logic [3:0]  be [8] = '{4'b1100, 4'b1100, 4'b0011, 4'b0010, 4'b0100, 4'b1111, 4'b1111, 4'b1111};
    logic [31:0] ex [8] = '{32'hFFFF_8001, 32'h0000_8001, 32'h0000_7FFF, 32'h0000_00F2,
                            32'h0000_0055, 32'hDEAD_BEEF, 32'h1234_5678, 32'h8000_0001};
    for (int i = 0; i < 8; i++) begin
      step(); drive(1, 0, sz[i], ad[i], 32'h0, 0, 32'h0);
      checks++; if (mem_bus.mem_be_o !== be[i]) begin errors++; $display("FAIL ld_be[%0d] got=%b exp=%b", i, mem_bus.mem_be_o, be[i]); end
      step(); drive(0, 0, 3'd0, 32'h0, 32'h0, 1, rd[i]);
      checks++; if ({core_bus.core_stall_o, core_bus.core_rd_o} !== {1'b0, ex[i]}) begin errors++;
        $display("FAIL ld_rd[%0d] got=%b/%h exp=0/%h", i, core_bus.core_stall_o, core_bus.core_rd_o, ex[i]); end
      $display("load size=%0d addr=%h mem=%h rd=%h", sz[i], ad[i], rd[i], core_bus.core_rd_o);
    end
  endtask

  task automatic test_timeout();
    step(); drive(1, 0, 3'd2, 32'h0000_0020, 32'h0, 0, 32'h0);
    checks++; if (ctl !== 7'b1101111) begin errors++; $display("FAIL to_issue_ctl got=%b exp=%b", ctl, 7'b1101111); end
    for (int c = 1; c <= 3; c++) begin
      step(); drive(0, 0, 3'd2, 32'h0, 32'h0, 0, 32'hFFFF_FFFF);
      checks++; if (hs !== 3'b110) begin errors++; $display("FAIL to_wait%0d got=%b exp=%b", c, hs, 3'b110); end
    end
    step(); drive(0, 0, 3'd2, 32'h0, 32'h0, 0, 32'hFFFF_FFFF);
    checks++; if ({hs, core_bus.core_rd_o} !== {3'b001, 32'h0}) begin errors++;
      $display("FAIL to_fire got=%b/%h exp=001/00000000", hs, core_bus.core_rd_o); end
    step(); drive(0, 0, 3'd2, 32'h0, 32'h0, 0, 32'h0);
    checks++; if (hs !== 3'b000) begin errors++; $display("FAIL to_after got=%b exp=%b", hs, 3'b000); end
    $display("load W addr=00000020 timed out");
  endtask

  task automatic test_ready_at_timeout();
    step(); drive(1, 0, 3'd2, 32'h0000_0024, 32'h0, 0, 32'h0);
    repeat (3) begin step(); drive(0, 0, 3'd2, 32'h0, 32'h0, 0, 32'h0); end
    step(); drive(0, 0, 3'd2, 32'h0, 32'h0, 1, 32'h0BAD_F00D);
    checks++; if ({hs, core_bus.core_rd_o} !== {3'b100, 32'h0BAD_F00D}) begin errors++;
      $display("FAIL rt_tie got=%b/%h exp=100/0badf00d", hs, core_bus.core_rd_o); end
    step(); drive(0, 0, 3'd2, 32'h0, 32'h0, 0, 32'h0);
    $display("load W addr=00000024 ready on last wait cycle rd=0badf00d");
  endtask

  task automatic test_reset_mid_wait();
    step(); drive(1, 0, 3'd2, 32'h0000_0030, 32'h0, 0, 32'h0);
    step(); drive(1, 0, 3'd2, 32'h0000_0030, 32'h0, 0, 32'h0);
    checks++; if (hs !== 3'b110) begin errors++; $display("FAIL rw_wait got=%b exp=%b", hs, 3'b110); end
    rst_n = 1'b0;
    #1;
    checks++; if ({mem_bus.mem_req_o, core_bus.core_stall_o} !== 2'b00) begin errors++;
      $display("FAIL rw_async got=%b exp=%b", {mem_bus.mem_req_o, core_bus.core_stall_o}, 2'b00); end
    step(); rst_n = 1'b1;
    drive(1, 0, 3'd2, 32'h0000_0040, 32'h0, 0, 32'h0);
    checks++; if ({hs, mem_bus.mem_addr_o} !== {3'b110, 32'h40}) begin errors++;
      $display("FAIL rw_reissue got=%b/%h exp=110/00000040", hs, mem_bus.mem_addr_o); end
    step(); drive(0, 0, 3'd2, 32'h0, 32'h0, 1, 32'h1122_3344);
    checks++; if (core_bus.core_rd_o !== 32'h1122_3344) begin errors++; $display("FAIL rw_rd got=%h exp=%h", core_bus.core_rd_o, 32'h1122_3344); end
    step(); drive(0, 0, 3'd2, 32'h0, 32'h0, 0, 32'h0);
    $display("reset during wait, reissued load W addr=00000040 rd=11223344");
  endtask

  task automatic test_misalign();
    step(); drive(1, 0, 3'd2, 32'h0000_0006, 32'h0, 0, 32'h0);
`ifdef LSU_MISALIGN_CHECK_EN
    checks++; if ({misalign, mem_bus.mem_req_o, core_bus.core_stall_o} !== 3'b100) begin errors++;
      $display("FAIL ma_reject got=%b exp=%b", {misalign, mem_bus.mem_req_o, core_bus.core_stall_o}, 3'b100); end
    step(); drive(0, 0, 3'd2, 32'h0, 32'h0, 0, 32'h0);
    checks++; if ({misalign, mem_bus.mem_req_o} !== 2'b00) begin errors++;
      $display("FAIL ma_stay_idle got=%b exp=%b", {misalign, mem_bus.mem_req_o}, 2'b00); end
    $display("load W addr=00000006 rejected as misaligned");
`else
    checks++; if ({misalign, mem_bus.mem_req_o, mem_bus.mem_addr_o} !== {2'b01, 32'h4}) begin errors++;
      $display("FAIL ma_issue got=%b/%h exp=01/00000004", {misalign, mem_bus.mem_req_o}, mem_bus.mem_addr_o); end
    step(); drive(0, 0, 3'd2, 32'h0, 32'h0, 1, 32'h7777_0000);
    checks++; if (core_bus.core_rd_o !== 32'h7777_0000) begin errors++; $display("FAIL ma_rd got=%h exp=%h", core_bus.core_rd_o, 32'h7777_0000); end
    step(); drive(0, 0, 3'd2, 32'h0, 32'h0, 0, 32'h0);
    $display("load W addr=00000006 issued at 00000004");
`endif
  endtask

  task automatic test_back_to_back();
    step(); drive(1, 0, 3'd2, 32'h0000_0100, 32'h0, 0, 32'h0);
    checks++; if ({hs, mem_bus.mem_addr_o} !== {3'b110, 32'h100}) begin errors++;
      $display("FAIL bb_first got=%b/%h exp=110/00000100", hs, mem_bus.mem_addr_o); end
    step(); drive(1, 0, 3'd2, 32'h0000_0104, 32'h0, 1, 32'hAAAA_5555);
    checks++; if ({hs, mem_bus.mem_addr_o, core_bus.core_rd_o} !== {3'b100, 32'h100, 32'hAAAA_5555}) begin errors++;
      $display("FAIL bb_done1 got=%b/%h/%h exp=100/00000100/aaaa5555", hs, mem_bus.mem_addr_o, core_bus.core_rd_o); end
    step(); drive(1, 0, 3'd2, 32'h0000_0104, 32'h0, 0, 32'h0);
    checks++; if ({hs, mem_bus.mem_addr_o} !== {3'b110, 32'h104}) begin errors++;
      $display("FAIL bb_second got=%b/%h exp=110/00000104", hs, mem_bus.mem_addr_o); end
    step(); drive(0, 0, 3'd2, 32'h0, 32'h0, 1, 32'h5555_AAAA);
    checks++; if ({hs, core_bus.core_rd_o} !== {3'b100, 32'h5555_AAAA}) begin errors++;
      $display("FAIL bb_done2 got=%b/%h exp=100/5555aaaa", hs, core_bus.core_rd_o); end
    step(); drive(0, 0, 3'd2, 32'h0, 32'h0, 0, 32'h0);
    checks++; if (hs !== 3'b000) begin errors++; $display("FAIL bb_idle got=%b exp=%b", hs, 3'b000); end
    $display("back-to-back loads W 00000100 / 00000104");
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_formats();
    test_load_formats();
    test_timeout();
    test_ready_at_timeout();
    test_reset_mid_wait();
    test_misalign();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_controller.md
LSU_CONTROLLER -- requirements
Module: lsu_controller

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 255: maximum number of WAIT cycles before an access is aborted.
REQ-002 clk_i  input  1  single clock; all state updates on the rising edge.
REQ-003 rst_i  input  1  reset, asynchronous, active-low.
REQ-004 core_req_i  input  1  core requests a data access for the current instruction.
REQ-005 core_we_i  input  1  1 = store, 0 = load.
REQ-006 core_size_i  input  3  access size: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
REQ-007 core_addr_i  input  32  byte address.
REQ-008 core_wd_i  input  32  store data, right-aligned.
REQ-009 core_rd_o  output  32  formatted load data.
REQ-010 core_stall_o  output  1  holds the core's PC and register-file write.
REQ-011 mem_req_o, mem_we_o  output  1 each  memory request and write strobe.
REQ-012 mem_be_o  output  4  byte enables.
REQ-013 mem_addr_o  output  32  word-aligned address (bits [1:0] = 0).
REQ-014 mem_wd_o  output  32  lane-replicated store data.
REQ-015 mem_rd_i  input  32  memory read word.
REQ-016 mem_ready_i  input  1  memory completes the access this cycle.
REQ-017 bus_err_o, misalign_o  output  1 each  single-cycle fault pulses.

Function
REQ-018 FSM states: IDLE and WAIT.
REQ-019 IDLE: when core_req_i=1 and the access is legal, the block SHALL drive mem_req_o=1 and core_stall_o=1 combinationally, and transition to WAIT.
REQ-020 WAIT: mem_req_o and core_stall_o SHALL stay 1 until mem_ready_i=1 or a timeout. The address, size, we and data are registered at IDLE->WAIT and held stable.
REQ-021 In the cycle mem_ready_i=1 in WAIT: core_stall_o=0, core_rd_o valid (combinational from mem_rd_i), next state IDLE.
REQ-022 Minimum access latency SHALL be 2 cycles: the issue cycle plus the ready cycle.
REQ-023 Byte lane SHALL be core_addr_i[1:0]; halfword lane SHALL be core_addr_i[1].
REQ-024 mem_be_o SHALL be: B = 0001<<lane; H = 0011<<(2*addr[1]); W = 1111.
REQ-025 mem_wd_o SHALL be: B = {4{wd[7:0]}}; H = {2{wd[15:0]}}; W = wd.
REQ-026 Loads: B/H SHALL be sign-extended, BU/HU zero-extended, W passed through.
REQ-027 Reserved sizes 3, 6 and 7 SHALL behave as W.
REQ-028 A WAIT-cycle counter SHALL be cleared on entry to WAIT and increment each cycle mem_ready_i=0. When it equals TIMEOUT_CYCLES: drop mem_req_o, pulse bus_err_o for 1 cycle, set core_stall_o=0 and core_rd_o=0, go to IDLE.
REQ-029 If mem_ready_i and the timeout coincide, ready SHALL win and bus_err_o SHALL stay 0.
REQ-030 TIMEOUT_CYCLES=0 SHALL disable the timeout.
REQ-031 core_req_i=0 in IDLE: mem_req_o=0, core_stall_o=0, core_rd_o=0.
REQ-032 A deassertion of core_req_i during WAIT SHALL be ignored; the access always completes or times out.
REQ-033 Back-to-back accesses: a new request in the cycle after completion SHALL be accepted from IDLE with no bubble.

Reset
REQ-034 While rst_i=0, the block SHALL immediately force: state IDLE, counter 0, mem_req_o=0, mem_we_o=0, mem_be_o=0, core_stall_o=0, bus_err_o=0, misalign_o=0, core_rd_o=0.
REQ-035 An access in flight at reset SHALL be abandoned; there is no replay after reset release.

Configuration
REQ-036 Macro LSU_MISALIGN_CHECK_EN SHALL enable misalignment checking.
REQ-037 With LSU_MISALIGN_CHECK_EN defined: H/HU with addr[0]=1, or W with addr[1:0]!=0, SHALL be rejected in IDLE. Required response: misalign_o=1 for that cycle, mem_req_o=0, core_stall_o=0, remain in IDLE.
REQ-038 Without LSU_MISALIGN_CHECK_EN: low address bits SHALL be ignored (H uses addr[1] only, W uses lane 0), misalign_o SHALL be tied 0, and every request SHALL be issued.

Structure
REQ-039 Package lsu_pkg SHALL hold the size constants (LDST_B, LDST_H, LDST_W, LDST_BU, LDST_HU) and the state enum type.
REQ-040 Sub-module lsu_load_formatter SHALL be the combinational lane select and extension; it holds no other logic.

Verification
REQ-041 Load B, addr=0x0000_0103, mem_rd_i=0x80FF_0000, ready on 2nd cycle -> core_rd_o=0xFFFF_FF80 in the ready cycle, core_stall_o=1 for exactly 1 cycle.
REQ-042 Store H, addr=0x0000_0012, wd=0x0000_ABCD -> mem_be_o=1100, mem_wd_o=0xABCD_ABCD, mem_addr_o=0x0000_0010, mem_we_o=1.
REQ-043 Load W with mem_ready_i held 0, TIMEOUT_CYCLES=4 -> bus_err_o pulses in WAIT cycle 4, mem_req_o falls, FSM returns to IDLE.
REQ-044 rst_i=0 mid-WAIT -> mem_req_o=0 and core_stall_o=0 immediately (no clock edge); the next request after release issues normally.
REQ-045 With LSU_MISALIGN_CHECK_EN, load W at addr 0x6 -> misalign_o=1, no mem_req_o. Without the macro -> mem_req_o=1 with mem_addr_o=0x4.
REQ-046 Two consecutive loads, ready immediate -> the second mem_req_o rises in the cycle after the first completes, with no idle gap.
